// File: rtl/bf16_convert_pipe.sv
// BF16 <-> FP32 conversion pipeline: S1 holds the accepted beat and feeds the
// classify/round logic, S2 is the output register. A single advance gates both stages.
`timescale 1ns/1ps

module bf16_convert_pipe #(
  parameter int LANES  = 2,
  parameter bit RTZ_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          operation,
  input  logic                rm,
  input  logic [32*LANES-1:0] operand,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] result,
  output logic [4*LANES-1:0]  lane_flags,
  input  logic                flag_clear,
  output logic [3:0]          fpcsr
);

  localparam logic [3:0] OP_BF2FP = 4'b0000;
  localparam logic [3:0] OP_FP2BF = 4'b0001;

  logic                adv;
  logic                s1_valid_q, s1_valid_d;
  logic [3:0]          s1_op_q, s1_op_d;
  logic                s1_rm_q, s1_rm_d;
  logic [32*LANES-1:0] s1_opnd_q, s1_opnd_d;
  logic                s2_valid_q, s2_valid_d;
  logic [32*LANES-1:0] s2_result_q, s2_result_d;
  logic [4*LANES-1:0]  s2_flags_q, s2_flags_d;
  logic [3:0]          fpcsr_q, fpcsr_d;
  logic [32*LANES-1:0] conv_result;
  logic [4*LANES-1:0]  conv_flags;
  logic [3:0]          beat_or;
  logic                out_xfer;

  // Returns {flags[3:0], result[31:0]} for one lane.
  function automatic logic [35:0] convert_lane(input logic [3:0] op, input logic rtz,
                                               input logic [31:0] x);
    logic [15:0] r;
    logic [3:0]  fl;
    logic [31:0] res;
    logic        rnd;
    r   = '0;
    fl  = '0;
    res = '0;
    rnd = 1'b0;
    case (op)
      OP_BF2FP: begin
        if (x[14:7] == 8'hFF && x[6:0] != 7'd0) begin
          res   = {x[15:7], 1'b1, x[5:0], 16'h0000};
          fl[0] = ~x[6];
        end else begin
          res = {x[15:0], 16'h0000};
        end
      end
      OP_FP2BF: begin
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
          r     = {x[31], 8'hFF, 1'b1, x[21:16]};
          fl[0] = ~x[22];
        end else if (x[30:0] == 31'd0 || x[30:0] == 31'h7F80_0000) begin
          r = x[31:16];
        end else begin
          rnd   = !rtz && x[15] && (x[14:0] != 15'd0 || x[16]);
          r     = x[31:16] + {15'd0, rnd};
          fl[3] = (x[15:0] != 16'd0);
          fl[1] = !rtz && (r[14:7] == 8'hFF);
          fl[2] = fl[3] && (r[14:7] == 8'h00);
        end
        res = {16'h0000, r};
      end
      default: fl = 4'b0001;
    endcase
    return {fl, res};
  endfunction

  always_comb begin
    conv_result = '0;
    conv_flags  = '0;
    for (int i = 0; i < LANES; i++) begin
      {conv_flags[4*i +: 4], conv_result[32*i +: 32]} =
        convert_lane(s1_op_q, RTZ_EN && s1_rm_q, s1_opnd_q[32*i +: 32]);
    end
  end

  always_comb begin
    adv        = !s2_valid_q || out_ready;
    in_ready   = adv && !reset;
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_rm_d    = s1_rm_q;
    s1_opnd_d  = s1_opnd_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d   = operation;
        s1_rm_d   = rm;
        s1_opnd_d = operand;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = conv_result;
        s2_flags_d  = conv_flags;
      end
    end
  end

  // Clear wins over accumulation, but the beat leaving this cycle still counts.
  always_comb begin
    out_xfer = s2_valid_q && out_ready;
    beat_or  = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_or = beat_or | s2_flags_q[4*i +: 4];
    end
    fpcsr_d = fpcsr_q;
    if (flag_clear) begin
      fpcsr_d = out_xfer ? beat_or : 4'h0;
    end else if (out_xfer) begin
      fpcsr_d = fpcsr_q | beat_or;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_rm_q     <= 1'b0;
      s1_opnd_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
      fpcsr_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_rm_q     <= s1_rm_d;
      s1_opnd_q   <= s1_opnd_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
      fpcsr_q     <= fpcsr_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign result     = s2_result_q;
  assign lane_flags = s2_flags_q;
  assign fpcsr      = fpcsr_q;

endmodule

// File: tb/tb_bf16_convert_pipe.sv
// Bench for bf16_convert_pipe: directed beats, backpressure, sticky flags, reset,
// then random traffic scored against a field-level reference model.
`timescale 1ns/1ps

module tb_bf16_convert_pipe;
  localparam int L      = 2;
  localparam bit RTZ_EN = 1'b1;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    operation;
  logic          rm;
  logic [32*L-1:0] operand;
  logic          out_valid;
  logic          out_ready;
  logic [32*L-1:0] result;
  logic [4*L-1:0]  lane_flags;
  logic          flag_clear;
  logic [3:0]    fpcsr;

  bf16_convert_pipe #(.LANES(L), .RTZ_EN(RTZ_EN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .rm(rm), .operand(operand), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .lane_flags(lane_flags),
    .flag_clear(flag_clear), .fpcsr(fpcsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [32*L-1:0] res;
    logic [4*L-1:0]  fl;
    int              acc;
  } beat_t;

  beat_t    sb[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  logic [3:0] exp_csr = 4'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: decode IEEE fields with integer arithmetic, round by comparing the
  // discarded half against the halfway point.
  function automatic logic [35:0] model_lane(input logic [3:0] op, input logic r_m,
                                             input logic [31:0] x);
    int unsigned hi, lo, e, m;
    logic [3:0]  fl;
    logic [31:0] r;
    bit          rtz;
    fl  = 4'h0;
    r   = 32'h0;
    rtz = RTZ_EN && r_m;
    hi  = x >> 16;
    lo  = x & 32'hFFFF;
    if (op == 4'd0) begin
      e = (lo >> 7) & 32'hFF;
      m = lo & 32'h7F;
      if (e == 255 && m != 0) begin
        r     = (lo | 32'h40) << 16;
        fl[0] = ((m & 32'h40) == 0);
      end else r = lo << 16;
    end else if (op == 4'd1) begin
      e = (x >> 23) & 32'hFF;
      m = x & 32'h7FFFFF;
      if (e == 255 && m != 0) begin
        r     = hi | 32'h40;
        fl[0] = ((m & 32'h400000) == 0);
      end else if (m == 0 && (e == 0 || e == 255)) begin
        r = hi;
      end else begin
        if (!rtz && (lo > 32'h8000 || (lo == 32'h8000 && (hi & 1) == 1)))
          hi = (hi + 1) & 32'hFFFF;
        r     = hi;
        e     = (hi >> 7) & 32'hFF;
        fl[3] = (lo != 0);
        fl[1] = !rtz && e == 255;
        fl[2] = fl[3] && e == 0;
      end
    end else fl = 4'h1;
    return {fl, r};
  endfunction

  function automatic beat_t model_beat(input logic [3:0] op, input logic r_m,
                                       input logic [32*L-1:0] opnd);
    beat_t b;
    for (int i = 0; i < L; i++)
      {b.fl[4*i +: 4], b.res[32*i +: 32]} = model_lane(op, r_m, opnd[32*i +: 32]);
    b.acc = cyc;
    return b;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w[30:23] = 8'hFF;
      1: w[30:23] = 8'h00;
      2: w[15:0]  = 16'h8000;
      3: w[14:7]  = 8'hFF;
      4: w[30:16] = 15'h7F7F;
      5: w[30:0]  = ($urandom_range(0, 1) == 1) ? 31'h7F80_0000 : 31'h0;
      6: w[14:0]  = ($urandom_range(0, 1) == 1) ? 15'h7F80 : 15'h0;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: drive at negedge, sample 1ns later, update scoreboard, step the edge.
  task automatic drive(input logic iv, input logic [3:0] op, input logic r_m,
                       input logic [32*L-1:0] opnd, input logic ordy, input logic fclr,
                       input logic rst, output logic acc);
    logic       exp_ov, xfer;
    logic [3:0] orf;
    in_valid = iv; operation = op; rm = r_m; operand = opnd;
    out_ready = ordy; flag_clear = fclr; reset = rst;
    #1;
    acc = 1'b0;
    if (rst) begin
      chk("in_ready_in_reset", in_ready, 0);
      sb.delete();
      exp_csr = 4'h0;
    end else begin
      exp_ov = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov && out_valid === 1'b1) begin
        chk("result", result, sb[0].res);
        chk("lane_flags", lane_flags, sb[0].fl);
      end
      chk("in_ready", in_ready, !(exp_ov && !ordy));
      xfer = exp_ov && ordy;
      orf  = 4'h0;
      if (xfer) begin
        for (int i = 0; i < L; i++) orf = orf | sb[0].fl[4*i +: 4];
        void'(sb.pop_front());
      end
      if (fclr) exp_csr = orf;
      else exp_csr = exp_csr | orf;
      if (iv && in_ready === 1'b1) begin
        sb.push_back(model_beat(op, r_m, opnd));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("fpcsr", fpcsr, exp_csr);
  endtask

  task automatic idle(input logic ordy, input logic fclr);
    logic a;
    drive(1'b0, 4'd0, 1'b0, '0, ordy, fclr, 1'b0, a);
  endtask

  initial begin
    logic a;
    logic [32*L-1:0] bp [4];
    int idx, stall;
    bit seen;

    reset = 1'b1; in_valid = 1'b0; operation = 4'd0; rm = 1'b0;
    operand = '0; out_ready = 1'b1; flag_clear = 1'b0;
    @(negedge clk);

    // reset state
    drive(1'b1, 4'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b1, a);
    drive(1'b0, 4'd0, 1'b0, '0, 1'b1, 1'b0, 1'b1, a);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_lane_flags", lane_flags, 0);
    chk("rst_fpcsr", fpcsr, 0);

    // BF16 -> FP32, including a signalling NaN lane
    drive(1'b1, 4'd0, 1'b0, {32'h0000_FF81, 32'h0000_3F80}, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1, 1'b0);
    chk("bf2fp_valid", out_valid, 1);
    chk("bf2fp_result", result, 64'hFFC1_0000_3F80_0000);
    chk("bf2fp_flags", lane_flags, 8'h10);

    // FP32 -> BF16 RNE ties
    drive(1'b1, 4'd1, 1'b0, {32'h3F81_8000, 32'h3F80_8000}, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1, 1'b0);
    chk("rne_result", result, 64'h0000_3F82_0000_3F80);
    chk("rne_flags", lane_flags, 8'h88);

    // overflow under RNE, then same input under RTZ on the next beat
    drive(1'b1, 4'd1, 1'b0, {2{32'h7F7F_FFFF}}, 1'b1, 1'b0, 1'b0, a);
    drive(1'b1, 4'd1, 1'b1, {2{32'h7F7F_FFFF}}, 1'b1, 1'b0, 1'b0, a);
    chk("ovf_rne_result", result, 64'h0000_7F80_0000_7F80);
    chk("ovf_rne_flags", lane_flags, 8'hAA);
    idle(1'b1, 1'b0);
    chk("ovf_rtz_result", result, 64'h0000_7F7F_0000_7F7F);
    chk("ovf_rtz_flags", lane_flags, 8'h88);
    idle(1'b1, 1'b0);

    // illegal opcode
    drive(1'b1, 4'd7, 1'b0, 64'h3F80_0000_4000_0000, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1, 1'b0);
    chk("illegal_result", result, 0);
    chk("illegal_flags", lane_flags, 8'h11);
    idle(1'b1, 1'b0);

    // backpressure: 4 beats, output stalled 3 cycles after first out_valid
    bp[0] = 64'h3F80_0001_4049_0FDB;
    bp[1] = 64'h0000_8001_C2F6_E979;
    bp[2] = 64'h7F80_0000_3F7F_FFFF;
    bp[3] = 64'h8000_0000_0001_8000;
    idx = 0; stall = 0; seen = 0;
    for (int k = 0; k < 40 && (idx < 4 || sb.size() > 0); k++) begin
      logic ordy;
      ordy = !(seen && stall < 3);
      drive(idx < 4, 4'd1, 1'b0, bp[idx & 3], ordy, 1'b0, 1'b0, a);
      if (!ordy) stall++;
      if (a) idx++;
      if (out_valid === 1'b1) seen = 1;
    end
    chk("bp_stall_cycles", stall, 3);
    chk("bp_all_sent", idx, 4);
    chk("bp_drained", sb.size(), 0);

    // sticky flags
    idle(1'b1, 1'b1);
    drive(1'b1, 4'd1, 1'b0, {2{32'h7F80_0001}}, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("sticky_snan", fpcsr, 4'h1);
    drive(1'b1, 4'd1, 1'b0, {2{32'h3F80_8000}}, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    chk("sticky_clear_xfer", fpcsr, 4'h8);

    // reset with two beats in flight
    drive(1'b1, 4'd1, 1'b0, {2{32'h7F80_0002}}, 1'b1, 1'b0, 1'b0, a);
    drive(1'b1, 4'd0, 1'b0, {2{32'h0000_FFA5}}, 1'b1, 1'b0, 1'b0, a);
    drive(1'b0, 4'd0, 1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_fpcsr", fpcsr, 0);
    drive(1'b1, 4'd1, 1'b1, {2{32'h4049_0FDB}}, 1'b1, 1'b0, 1'b0, a);
    chk("accept_after_reset", a, 1);
    for (int k = 0; k < 4; k++) idle(1'b1, 1'b0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      int unsigned sel;
      logic [3:0] op;
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? 4'd1 : (sel < 9) ? 4'd0 : 4'($urandom_range(2, 15));
      drive($urandom_range(0, 3) != 0, op, 1'($urandom_range(0, 1)),
            {rand_word(), rand_word()}, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0, a);
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) idle(1'b1, 1'b0);
    chk("final_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
